hex_display_ctrl: RTL and testbench



---
 rtl/hexdisp_pkg.sv | 17 +
 rtl/hex7seg_dec.sv | 11 +
 rtl/hex_display_ctrl.sv | 86 ++++++++
 tb/tb_hex_display_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/hexdisp_pkg.sv
// Shared constants for the seven-segment display driver.
// Segment patterns are active-low, stored as {g,f,e,d,c,b,a}.
package hexdisp_pkg;

    localparam int SEG_W = 7;
    localparam int NIB_W = 4;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    localparam logic [SEG_W-1:0] GLYPH_TABLE [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational nibble-to-glyph decoder for one active-low seven-segment digit.
module hex7seg_dec
    import hexdisp_pkg::*;
(
    input  logic [NIB_W-1:0] nibble,
    output logic [SEG_W-1:0] glyph
);

    assign glyph = GLYPH_TABLE[nibble];

endmodule

// File: rtl/hex_display_ctrl.sv
// Multi-digit hex display driver with per-digit blinking and a load acknowledge.
// Optional leading-zero blanking is enabled by defining HEXDISP_LZB_EN.
module hex_display_ctrl
    import hexdisp_pkg::*;
#(
    parameter int DIGITS   = 6,
    parameter int CLK_HZ   = 50000000,
    parameter int BLINK_HZ = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [NIB_W*DIGITS-1:0] data,
    input  logic [DIGITS-1:0]       blink_mask,
    output logic [SEG_W*DIGITS-1:0] seg,
    output logic                    updated
);

    localparam int HALF  = CLK_HZ / (2 * BLINK_HZ);
    localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;

    logic [NIB_W*DIGITS-1:0] data_q;
    logic [DIGITS-1:0]       mask_q;
    logic                    pend_q;
    logic [CNT_W-1:0]        cnt;
    logic                    phase;
    logic [SEG_W*DIGITS-1:0] glyphs;
    logic [DIGITS-1:0]       lzb;
    logic [DIGITS-1:0]       hidden;

    for (genvar g = 0; g < DIGITS; g++) begin : gen_dec
        hex7seg_dec u_dec (
            .nibble (data_q[NIB_W*g +: NIB_W]),
            .glyph  (glyphs[SEG_W*g +: SEG_W])
        );
    end

    always_comb begin
        lzb = '0;
`ifdef HEXDISP_LZB_EN
        begin : lzb_scan
            logic seen;
            seen = 1'b0;
            // Walk down from the top; a digit is blanked until the first non-zero one.
            for (int i = DIGITS - 1; i >= 1; i--) begin
                seen   = seen | (data_q[NIB_W*i +: NIB_W] != '0);
                lzb[i] = ~seen;
            end
        end
`endif
    end

    assign hidden = ({DIGITS{phase}} & mask_q) | lzb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            mask_q  <= '0;
            pend_q  <= 1'b0;
            cnt     <= '0;
            phase   <= 1'b0;
            seg     <= {DIGITS{SEG_BLANK}};
            updated <= 1'b0;
        end else begin
            pend_q <= load;
            if (load) begin
                data_q <= data;
                mask_q <= blink_mask;
            end

            // Free-running blink divider; loads never disturb it.
            if (cnt == CNT_W'(HALF - 1)) begin
                cnt   <= '0;
                phase <= ~phase;
            end else begin
                cnt <= cnt + 1'b1;
            end

            for (int i = 0; i < DIGITS; i++) begin
                seg[SEG_W*i +: SEG_W] <= hidden[i] ? SEG_BLANK : glyphs[SEG_W*i +: SEG_W];
            end
            updated <= pend_q;
        end
    end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed self-checking bench for hex_display_ctrl with 4 digits and a 4-cycle blink half-period.
// Expected values follow the HEXDISP_LZB_EN setting of the build.
module tb_hex_display_ctrl;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] data;
    logic [3:0]  blink_mask;
    logic [27:0] seg;
    logic        updated;

    int total;
    int passed;

    hex_display_ctrl #(
        .DIGITS   (4),
        .CLK_HZ   (8),
        .BLINK_HZ (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .data       (data),
        .blink_mask (blink_mask),
        .seg        (seg),
        .updated    (updated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [27:0] observed, input logic [27:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic [15:0] value, input logic [3:0] mask);
        load       = 1'b1;
        data       = value;
        blink_mask = mask;
        tick();
        load = 1'b0;
    endtask

    function automatic logic [6:0] digit(input logic [27:0] s, input int i);
        return s[7*i +: 7];
    endfunction

    initial begin
        total      = 0;
        passed     = 0;
        rst        = 1'b1;
        load       = 1'b0;
        data       = '0;
        blink_mask = '0;
        tick();
        tick();
        checkOutput("reset_seg", seg, {4{7'h7F}});
        checkOutput("reset_updated", {27'd0, updated}, 28'd0);

        // Release between edges; edge count e starts here so blink phase is predictable.
        rst = 1'b0;
        tick();
`ifdef HEXDISP_LZB_EN
        checkOutput("post_reset_seg", seg, {7'h7F, 7'h7F, 7'h7F, 7'h40});
`else
        checkOutput("post_reset_seg", seg, {4{7'h40}});
`endif
        checkOutput("post_reset_updated", {27'd0, updated}, 28'd0);

        applyStimulus(16'h00A5, 4'b0001);
        tick();
        checkOutput("blink_load_updated", {27'd0, updated}, 28'd1);
        checkOutput("blink_d0_first", {21'd0, digit(seg, 0)}, {21'd0, 7'h12});
        // Digit 0 shows for edges 3..4, blank 5..8, shows 9..12, blank 13.
        for (int e = 4; e <= 13; e++) begin
            tick();
            checkOutput("blink_d0", {21'd0, digit(seg, 0)},
                        {21'd0, ((((e - 1) / 4) % 2) == 0) ? 7'h12 : 7'h7F});
            checkOutput("blink_d1", {21'd0, digit(seg, 1)}, {21'd0, 7'h08});
        end
        checkOutput("blink_updated_low", {27'd0, updated}, 28'd0);

        // Load while phase=1 (edge 14); the divider must keep its schedule.
        applyStimulus(16'h00B6, 4'b0001);
        tick();
        checkOutput("phase1_load_d0", {21'd0, digit(seg, 0)}, {21'd0, 7'h7F});
        checkOutput("phase1_load_d1", {21'd0, digit(seg, 1)}, {21'd0, 7'h03});
        checkOutput("phase1_load_updated", {27'd0, updated}, 28'd1);
        tick();
        checkOutput("phase1_hold_d0", {21'd0, digit(seg, 0)}, {21'd0, 7'h7F});
        tick();
        checkOutput("phase_toggle_d0", {21'd0, digit(seg, 0)}, {21'd0, 7'h02});

        applyStimulus(16'h0123, 4'b0000);
        checkOutput("sweep0_updated_pre", {27'd0, updated}, 28'd0);
        tick();
`ifdef HEXDISP_LZB_EN
        checkOutput("sweep0_seg", seg, {7'h7F, 7'h79, 7'h24, 7'h30});
`else
        checkOutput("sweep0_seg", seg, {7'h40, 7'h79, 7'h24, 7'h30});
`endif
        checkOutput("sweep0_updated", {27'd0, updated}, 28'd1);
        tick();
        checkOutput("sweep0_updated_post", {27'd0, updated}, 28'd0);

        applyStimulus(16'h4567, 4'b0000);
        tick();
        checkOutput("sweep1_seg", seg, {7'h19, 7'h12, 7'h02, 7'h78});
        checkOutput("sweep1_updated", {27'd0, updated}, 28'd1);
        tick();
        checkOutput("sweep1_updated_post", {27'd0, updated}, 28'd0);

        applyStimulus(16'h89AB, 4'b0000);
        tick();
        checkOutput("sweep2_seg", seg, {7'h00, 7'h10, 7'h08, 7'h03});
        checkOutput("sweep2_updated", {27'd0, updated}, 28'd1);

        applyStimulus(16'hCDEF, 4'b0000);
        tick();
        checkOutput("sweep3_seg", seg, {7'h46, 7'h21, 7'h06, 7'h0E});
        checkOutput("sweep3_updated", {27'd0, updated}, 28'd1);
        tick();
        checkOutput("sweep3_updated_post", {27'd0, updated}, 28'd0);

        applyStimulus(16'h0050, 4'b0000);
        tick();
`ifdef HEXDISP_LZB_EN
        checkOutput("lzb_0050", seg, {7'h7F, 7'h7F, 7'h12, 7'h40});
`else
        checkOutput("lzb_0050", seg, {7'h40, 7'h40, 7'h12, 7'h40});
`endif

        applyStimulus(16'h0000, 4'b0000);
        tick();
`ifdef HEXDISP_LZB_EN
        checkOutput("lzb_0000", seg, {7'h7F, 7'h7F, 7'h7F, 7'h40});
`else
        checkOutput("lzb_0000", seg, {4{7'h40}});
`endif

        // Back-to-back loads on consecutive edges.
        load       = 1'b1;
        data       = 16'h1111;
        blink_mask = 4'b0000;
        tick();
        data = 16'h2222;
        tick();
        load = 1'b0;
        checkOutput("b2b_first_seg", seg, {4{7'h79}});
        checkOutput("b2b_first_updated", {27'd0, updated}, 28'd1);
        tick();
        checkOutput("b2b_final_seg", seg, {4{7'h24}});
        checkOutput("b2b_second_updated", {27'd0, updated}, 28'd1);
        tick();
        checkOutput("b2b_updated_post", {27'd0, updated}, 28'd0);

        // Reset asserted between edges with a load pending takes effect immediately.
        applyStimulus(16'h3333, 4'b1111);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrun_reset_seg", seg, {4{7'h7F}});
        checkOutput("midrun_reset_updated", {27'd0, updated}, 28'd0);
        tick();
        rst = 1'b0;
        tick();
`ifdef HEXDISP_LZB_EN
        checkOutput("midrun_release_seg", seg, {7'h7F, 7'h7F, 7'h7F, 7'h40});
`else
        checkOutput("midrun_release_seg", seg, {4{7'h40}});
`endif
        checkOutput("midrun_release_updated", {27'd0, updated}, 28'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
